// File: rtl/exec_pkg.sv
// Shared types and defaults for the EX stage and its multiply/divide unit.
package exec_pkg;

    localparam int unsigned XlenDef  = 32;
    localparam int unsigned RegAwDef = 5;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4,
        AluNor = 3'd5,
        AluSlt = 3'd6,
        AluLui = 3'd7
    } aluop_e;

    typedef enum logic [1:0] {
        ShSll  = 2'd0,
        ShSrl  = 2'd1,
        ShSra  = 2'd2,
        ShRotr = 2'd3
    } shiftop_e;

    typedef enum logic [2:0] {
        MduNone  = 3'd0,
        MduMult  = 3'd1,
        MduMultu = 3'd2,
        MduDiv   = 3'd3,
        MduDivu  = 3'd4,
        MduMfhi  = 3'd5,
        MduMflo  = 3'd6
    } mduop_e;

    typedef enum logic [0:0] {
        MduIdle = 1'b0,
        MduRun  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/exec_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master is the pipeline around the stage, slave is exec_stage.
interface exec_if
    import exec_pkg::*;
#(
    parameter int unsigned XLEN   = XlenDef,
    parameter int unsigned REG_AW = RegAwDef
) ();

    logic                    id_ex_valid;
    logic                    id_ex_selalushift;
    logic                    id_ex_selimregb;
    logic                    id_ex_unsig;
    logic                    id_ex_readmem;
    logic                    id_ex_writemem;
    logic                    id_ex_selwsource;
    logic                    id_ex_writereg;
    logic                    id_ex_writeov;
    aluop_e                  id_ex_aluop;
    shiftop_e                id_ex_shiftop;
    logic [$clog2(XLEN)-1:0] id_ex_shiftamt;
    mduop_e                  id_ex_mduop;
    logic [XLEN-1:0]         id_ex_rega;
    logic [XLEN-1:0]         id_ex_regb;
    logic [XLEN-1:0]         id_ex_imedext;
    logic [REG_AW-1:0]       id_ex_regdest;
    logic                    mem_stall;
    logic                    flush;

    logic                    ex_busy;
    logic                    ex_mem_valid;
    logic                    ex_mem_readmem;
    logic                    ex_mem_writemem;
    logic                    ex_mem_selwsource;
    logic                    ex_mem_writereg;
    logic                    ex_mem_ovf;
    logic [XLEN-1:0]         ex_mem_regb;
    logic [XLEN-1:0]         ex_mem_wbvalue;
    logic [REG_AW-1:0]       ex_mem_regdest;

    modport master (
        output id_ex_valid, id_ex_selalushift, id_ex_selimregb, id_ex_unsig, id_ex_readmem,
               id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov, id_ex_aluop,
               id_ex_shiftop, id_ex_shiftamt, id_ex_mduop, id_ex_rega, id_ex_regb,
               id_ex_imedext, id_ex_regdest, mem_stall, flush,
        input  ex_busy, ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource,
               ex_mem_writereg, ex_mem_ovf, ex_mem_regb, ex_mem_wbvalue, ex_mem_regdest
    );

    modport slave (
        input  id_ex_valid, id_ex_selalushift, id_ex_selimregb, id_ex_unsig, id_ex_readmem,
               id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov, id_ex_aluop,
               id_ex_shiftop, id_ex_shiftamt, id_ex_mduop, id_ex_rega, id_ex_regb,
               id_ex_imedext, id_ex_regdest, mem_stall, flush,
        output ex_busy, ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource,
               ex_mem_writereg, ex_mem_ovf, ex_mem_regb, ex_mem_wbvalue, ex_mem_regdest
    );

endinterface

// File: rtl/exec_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// XLEN cycles per operation, results land in HI/LO on the last step.
module exec_mdu
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = XlenDef
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  mduop_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    mdu_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            is_div_q, neg_q, rem_neg_q, div0_q;
    // acc: partial product high half (mult) or partial remainder (div)
    logic [XLEN:0]   acc_q;
    logic [XLEN-1:0] sh_q, opb_q, hi_q, lo_q;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   sum, shifted, diff, acc_n;
    logic [XLEN-1:0] sh_n, quo, rem, hi_n, lo_n;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        sign_a = (op_i == MduMult || op_i == MduDiv) && a_i[XLEN-1];
        sign_b = (op_i == MduMult || op_i == MduDiv) && b_i[XLEN-1];
        mag_a  = sign_a ? -a_i : a_i;
        mag_b  = sign_b ? -b_i : b_i;

        sum     = acc_q + (sh_q[0] ? {1'b0, opb_q} : '0);
        shifted = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
        diff    = shifted - {1'b0, opb_q};

        if (is_div_q) begin
            acc_n = diff[XLEN] ? shifted : diff;
            sh_n  = {sh_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_n = {1'b0, sum[XLEN:1]};
            sh_n  = {sum[0], sh_q[XLEN-1:1]};
        end

        prod = {acc_n[XLEN-1:0], sh_n};
        if (neg_q) prod = -prod;
        quo = sh_n;
        rem = acc_n[XLEN-1:0];

        if (is_div_q) begin
            // A zero divisor already yields rem = |a|, so only the quotient needs forcing
            lo_n = div0_q ? '1 : (neg_q ? -quo : quo);
            hi_n = rem_neg_q ? -rem : rem;
        end else begin
            lo_n = prod[XLEN-1:0];
            hi_n = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MduIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_q     <= '0;
            sh_q      <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                MduIdle: begin
                    if (start_i) begin
                        state_q   <= MduRun;
                        cnt_q     <= '0;
                        is_div_q  <= (op_i == MduDiv || op_i == MduDivu);
                        neg_q     <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        div0_q    <= (b_i == '0);
                        acc_q     <= '0;
                        sh_q      <= mag_a;
                        opb_q     <= mag_b;
                    end
                end
                MduRun: begin
                    acc_q <= acc_n;
                    sh_q  <= sh_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        hi_q    <= hi_n;
                        lo_q    <= lo_n;
                        state_q <= MduIdle;
                    end
                end
                default: state_q <= MduIdle;
            endcase
        end
    end

    assign busy_o = (state_q == MduRun);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/exec_stage.sv
// EX stage: ALU, shifter, overflow-gated writeback and the EX/MEM register.
// Define EXEC_MDU_EN to add the iterative multiply/divide unit with HI/LO.
module exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned XLEN   = XlenDef,
    parameter int unsigned REG_AW = RegAwDef
) (
    input  logic  clock,
    input  logic  reset,
    exec_if.slave ex_io
);

    logic [XLEN-1:0]   opb, alu_res, sh_res, wb_val;
    logic              alu_ov, is_muldiv, wr_block, busy;

    logic              valid_q, readmem_q, writemem_q, selws_q, writereg_q, ovf_q;
    logic              valid_d, readmem_d, writemem_d, selws_d, writereg_d, ovf_d;
    logic [XLEN-1:0]   regb_q, wbvalue_q, regb_d, wbvalue_d;
    logic [REG_AW-1:0] regdest_q, regdest_d;

    assign opb       = ex_io.id_ex_selimregb ? ex_io.id_ex_imedext : ex_io.id_ex_regb;
    assign is_muldiv = (ex_io.id_ex_mduop == MduMult) || (ex_io.id_ex_mduop == MduMultu) ||
                       (ex_io.id_ex_mduop == MduDiv)  || (ex_io.id_ex_mduop == MduDivu);

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (ex_io.id_ex_aluop)
            AluAdd: begin
                alu_res = ex_io.id_ex_rega + opb;
                alu_ov  = !ex_io.id_ex_unsig && (ex_io.id_ex_rega[XLEN-1] == opb[XLEN-1]) &&
                          (alu_res[XLEN-1] != ex_io.id_ex_rega[XLEN-1]);
            end
            AluSub: begin
                alu_res = ex_io.id_ex_rega - opb;
                alu_ov  = !ex_io.id_ex_unsig && (ex_io.id_ex_rega[XLEN-1] != opb[XLEN-1]) &&
                          (alu_res[XLEN-1] != ex_io.id_ex_rega[XLEN-1]);
            end
            AluAnd: alu_res = ex_io.id_ex_rega & opb;
            AluOr:  alu_res = ex_io.id_ex_rega | opb;
            AluXor: alu_res = ex_io.id_ex_rega ^ opb;
            AluNor: alu_res = ~(ex_io.id_ex_rega | opb);
            AluSlt: alu_res = {{(XLEN-1){1'b0}}, ex_io.id_ex_unsig ?
                               (ex_io.id_ex_rega < opb) :
                               ($signed(ex_io.id_ex_rega) < $signed(opb))};
            AluLui: alu_res = opb << (XLEN / 2);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        sh_res = '0;
        case (ex_io.id_ex_shiftop)
            ShSll:  sh_res = ex_io.id_ex_regb << ex_io.id_ex_shiftamt;
            ShSrl:  sh_res = ex_io.id_ex_regb >> ex_io.id_ex_shiftamt;
            ShSra:  sh_res = $signed(ex_io.id_ex_regb) >>> ex_io.id_ex_shiftamt;
            ShRotr: sh_res = (ex_io.id_ex_regb >> ex_io.id_ex_shiftamt) |
                             (ex_io.id_ex_regb << (XLEN - 32'(ex_io.id_ex_shiftamt)));
            default: sh_res = '0;
        endcase
    end

`ifdef EXEC_MDU_EN
    logic            mdu_busy, mdu_start;
    logic [XLEN-1:0] mdu_hi, mdu_lo;

    assign busy      = ex_io.id_ex_valid && mdu_busy && (ex_io.id_ex_mduop != MduNone);
    assign mdu_start = ex_io.id_ex_valid && is_muldiv && !ex_io.flush && !ex_io.mem_stall &&
                       !busy;
    assign wr_block  = is_muldiv;

    exec_mdu #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk_i   (clock),
        .rst_ni  (reset),
        .start_i (mdu_start),
        .op_i    (ex_io.id_ex_mduop),
        .a_i     (ex_io.id_ex_rega),
        .b_i     (ex_io.id_ex_regb),
        .busy_o  (mdu_busy),
        .hi_o    (mdu_hi),
        .lo_o    (mdu_lo)
    );

    always_comb begin
        if (ex_io.id_ex_mduop == MduMfhi)      wb_val = mdu_hi;
        else if (ex_io.id_ex_mduop == MduMflo) wb_val = mdu_lo;
        else if (is_muldiv)                    wb_val = '0;
        else if (ex_io.id_ex_selalushift)      wb_val = sh_res;
        else                                   wb_val = alu_res;
    end
`else
    // Without the MDU every mduop other than none retires as a NOP
    assign busy     = 1'b0;
    assign wr_block = (ex_io.id_ex_mduop != MduNone);
    assign wb_val   = wr_block ? '0 : (ex_io.id_ex_selalushift ? sh_res : alu_res);
`endif

    always_comb begin
        valid_d    = valid_q;
        readmem_d  = readmem_q;
        writemem_d = writemem_q;
        selws_d    = selws_q;
        writereg_d = writereg_q;
        ovf_d      = ovf_q;
        regb_d     = regb_q;
        wbvalue_d  = wbvalue_q;
        regdest_d  = regdest_q;
        if (ex_io.flush) begin
            valid_d    = 1'b0;
            readmem_d  = 1'b0;
            writemem_d = 1'b0;
            writereg_d = 1'b0;
            ovf_d      = 1'b0;
        end else if (!ex_io.mem_stall) begin
            // While busy the held instruction leaves a bubble behind it
            valid_d    = !busy && ex_io.id_ex_valid;
            readmem_d  = !busy && ex_io.id_ex_readmem;
            writemem_d = !busy && ex_io.id_ex_writemem;
            selws_d    = !busy && ex_io.id_ex_selwsource;
            writereg_d = !busy && ex_io.id_ex_valid && ex_io.id_ex_writereg &&
                         (!alu_ov || ex_io.id_ex_writeov) && !wr_block;
            ovf_d      = !busy && ex_io.id_ex_valid && alu_ov && !ex_io.id_ex_writeov;
            regb_d     = ex_io.id_ex_regb;
            wbvalue_d  = wb_val;
            regdest_d  = ex_io.id_ex_regdest;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            readmem_q  <= 1'b0;
            writemem_q <= 1'b0;
            selws_q    <= 1'b0;
            writereg_q <= 1'b0;
            ovf_q      <= 1'b0;
            regb_q     <= '0;
            wbvalue_q  <= '0;
            regdest_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            readmem_q  <= readmem_d;
            writemem_q <= writemem_d;
            selws_q    <= selws_d;
            writereg_q <= writereg_d;
            ovf_q      <= ovf_d;
            regb_q     <= regb_d;
            wbvalue_q  <= wbvalue_d;
            regdest_q  <= regdest_d;
        end
    end

    assign ex_io.ex_busy           = busy;
    assign ex_io.ex_mem_valid      = valid_q;
    assign ex_io.ex_mem_readmem    = readmem_q;
    assign ex_io.ex_mem_writemem   = writemem_q;
    assign ex_io.ex_mem_selwsource = selws_q;
    assign ex_io.ex_mem_writereg   = writereg_q;
    assign ex_io.ex_mem_ovf        = ovf_q;
    assign ex_io.ex_mem_regb       = regb_q;
    assign ex_io.ex_mem_wbvalue    = wbvalue_q;
    assign ex_io.ex_mem_regdest    = regdest_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage (XLEN=32); MDU checks follow EXEC_MDU_EN.
module tb_exec_stage;
    import exec_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_busy, n_bubble;

    exec_if #(.XLEN(32), .REG_AW(5)) ex_io ();

    exec_stage #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ex_io (ex_io)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ex_io.id_ex_valid       = 1'b0;
        ex_io.id_ex_selalushift = 1'b0;
        ex_io.id_ex_selimregb   = 1'b0;
        ex_io.id_ex_unsig       = 1'b0;
        ex_io.id_ex_readmem     = 1'b0;
        ex_io.id_ex_writemem    = 1'b0;
        ex_io.id_ex_selwsource  = 1'b0;
        ex_io.id_ex_writereg    = 1'b0;
        ex_io.id_ex_writeov     = 1'b0;
        ex_io.id_ex_aluop       = AluAdd;
        ex_io.id_ex_shiftop     = ShSll;
        ex_io.id_ex_shiftamt    = '0;
        ex_io.id_ex_mduop       = MduNone;
        ex_io.id_ex_rega        = '0;
        ex_io.id_ex_regb        = '0;
        ex_io.id_ex_imedext     = '0;
        ex_io.id_ex_regdest     = '0;
        ex_io.mem_stall         = 1'b0;
        ex_io.flush             = 1'b0;
    endtask

    task automatic alu_op(input aluop_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic selimm, input logic wov);
        idle();
        ex_io.id_ex_valid     = 1'b1;
        ex_io.id_ex_writereg  = 1'b1;
        ex_io.id_ex_aluop     = op;
        ex_io.id_ex_rega      = a;
        ex_io.id_ex_regb      = b;
        ex_io.id_ex_imedext   = imm;
        ex_io.id_ex_selimregb = selimm;
        ex_io.id_ex_writeov   = wov;
    endtask

    task automatic shift_op(input shiftop_e op, input logic [31:0] b, input logic [4:0] amt);
        alu_op(AluAdd, 32'd0, b, 32'd0, 1'b0, 1'b0);
        ex_io.id_ex_selalushift = 1'b1;
        ex_io.id_ex_shiftop     = op;
        ex_io.id_ex_shiftamt    = amt;
    endtask

    task automatic mdu_op(input mduop_e op, input logic [31:0] a, input logic [31:0] b);
        idle();
        ex_io.id_ex_valid    = 1'b1;
        ex_io.id_ex_writereg = 1'b1;
        ex_io.id_ex_mduop    = op;
        ex_io.id_ex_rega     = a;
        ex_io.id_ex_regb     = b;
    endtask

    // Drive a HI/LO read, wait out the MDU, then check the captured value
    task automatic mdu_read(input string tag, input mduop_e op, input logic [31:0] exp);
        int n;
        mdu_op(op, 32'd0, 32'd0);
        n = 0;
        while (ex_io.ex_busy && n < 40) begin
            tick();
            n++;
        end
        check({tag, " busy timeout"}, ex_io.ex_busy, 1'b0);
        tick();
        check(tag, ex_io.ex_mem_wbvalue, exp);
        check({tag, " writereg"}, ex_io.ex_mem_writereg, 1'b1);
    endtask

    initial begin
        idle();
        #12;
        check("reset valid", ex_io.ex_mem_valid, 1'b0);
        check("reset wbvalue", ex_io.ex_mem_wbvalue, 32'd0);
        check("reset writereg", ex_io.ex_mem_writereg, 1'b0);
        check("reset busy", ex_io.ex_busy, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        alu_op(AluAdd, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1, 1'b0);
        tick();
        check("addov wbvalue", ex_io.ex_mem_wbvalue, 32'h8000_0000);
        check("addov writereg", ex_io.ex_mem_writereg, 1'b0);
        check("addov ovf", ex_io.ex_mem_ovf, 1'b1);
        check("addov valid", ex_io.ex_mem_valid, 1'b1);
        ex_io.id_ex_writeov = 1'b1;
        tick();
        check("addovw writereg", ex_io.ex_mem_writereg, 1'b1);
        check("addovw ovf", ex_io.ex_mem_ovf, 1'b0);

        alu_op(AluSub, 32'd5, 32'd9, 32'd0, 1'b0, 1'b0);
        tick();
        check("sub wbvalue", ex_io.ex_mem_wbvalue, 32'hFFFF_FFFC);
        check("sub ovf", ex_io.ex_mem_ovf, 1'b0);
        alu_op(AluSlt, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        tick();
        check("slt", ex_io.ex_mem_wbvalue, 32'd1);
        ex_io.id_ex_unsig = 1'b1;
        tick();
        check("sltu", ex_io.ex_mem_wbvalue, 32'd0);
        shift_op(ShSra, 32'h8000_0010, 5'd4);
        tick();
        check("sra", ex_io.ex_mem_wbvalue, 32'hF800_0001);
        shift_op(ShRotr, 32'h1234_5678, 5'd8);
        tick();
        check("rotr", ex_io.ex_mem_wbvalue, 32'h7812_3456);
        shift_op(ShSll, 32'h0000_0003, 5'd31);
        tick();
        check("sll", ex_io.ex_mem_wbvalue, 32'h8000_0000);

        // Load held in EX/MEM by a memory stall, then flushed
        alu_op(AluAdd, 32'h100, 32'h55, 32'd4, 1'b1, 1'b0);
        ex_io.id_ex_readmem    = 1'b1;
        ex_io.id_ex_selwsource = 1'b1;
        ex_io.id_ex_regdest    = 5'd8;
        tick();
        check("lw wbvalue", ex_io.ex_mem_wbvalue, 32'h104);
        check("lw readmem", ex_io.ex_mem_readmem, 1'b1);
        alu_op(AluSub, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0);
        ex_io.mem_stall = 1'b1;
        repeat (3) tick();
        check("stall wbvalue", ex_io.ex_mem_wbvalue, 32'h104);
        check("stall readmem", ex_io.ex_mem_readmem, 1'b1);
        check("stall regdest", ex_io.ex_mem_regdest, 32'd8);
        check("stall regb", ex_io.ex_mem_regb, 32'h55);
        ex_io.flush = 1'b1;
        tick();
        check("flush valid", ex_io.ex_mem_valid, 1'b0);
        check("flush readmem", ex_io.ex_mem_readmem, 1'b0);
        check("flush writereg", ex_io.ex_mem_writereg, 1'b0);

`ifdef EXEC_MDU_EN
        mdu_op(MduMult, 32'hFFFF_FFFD, 32'd7);
        tick();
        check("mult valid", ex_io.ex_mem_valid, 1'b1);
        check("mult writereg", ex_io.ex_mem_writereg, 1'b0);
        check("mult wbvalue", ex_io.ex_mem_wbvalue, 32'd0);
        mdu_op(MduMflo, 32'd0, 32'd0);
        n_busy   = 0;
        n_bubble = 0;
        while (ex_io.ex_busy && n_busy < 40) begin
            n_busy++;
            tick();
            if (!ex_io.ex_mem_valid) n_bubble++;
        end
        check("mult busy cycles", n_busy, 32'd32);
        check("mult bubbles", n_bubble, 32'd32);
        tick();
        check("mult mflo", ex_io.ex_mem_wbvalue, 32'hFFFF_FFEB);
        check("mult mflo valid", ex_io.ex_mem_valid, 1'b1);
        mdu_read("mult mfhi", MduMfhi, 32'hFFFF_FFFF);

        mdu_op(MduDiv, 32'hFFFF_FFF9, 32'd2);
        tick();
        mdu_read("div mflo", MduMflo, 32'hFFFF_FFFD);
        mdu_read("div mfhi", MduMfhi, 32'hFFFF_FFFF);
        mdu_op(MduDivu, 32'd5, 32'd0);
        tick();
        mdu_read("divu0 mflo", MduMflo, 32'hFFFF_FFFF);
        mdu_read("divu0 mfhi", MduMfhi, 32'd5);

        // Asynchronous reset in the middle of a divide
        mdu_op(MduDiv, 32'd100, 32'd7);
        tick();
        alu_op(AluAdd, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        repeat (10) tick();
        mdu_op(MduMflo, 32'd0, 32'd0);
        #1;
        check("rst pre busy", ex_io.ex_busy, 1'b1);
        check("rst pre wbvalue", ex_io.ex_mem_wbvalue, 32'd2);
        #1 reset = 1'b0;
        #1;
        check("rst valid", ex_io.ex_mem_valid, 1'b0);
        check("rst wbvalue", ex_io.ex_mem_wbvalue, 32'd0);
        check("rst busy", ex_io.ex_busy, 1'b0);
        #2 reset = 1'b1;
        tick();
        check("rst mflo", ex_io.ex_mem_wbvalue, 32'd0);
        check("rst mflo valid", ex_io.ex_mem_valid, 1'b1);
`else
        alu_op(AluAdd, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        ex_io.id_ex_mduop = MduMult;
        #1;
        check("nomdu busy", ex_io.ex_busy, 1'b0);
        tick();
        check("nomdu valid", ex_io.ex_mem_valid, 1'b1);
        check("nomdu writereg", ex_io.ex_mem_writereg, 1'b0);
        check("nomdu wbvalue", ex_io.ex_mem_wbvalue, 32'd0);
        ex_io.id_ex_mduop = MduMflo;
        tick();
        check("nomdu mflo writereg", ex_io.ex_mem_writereg, 1'b0);
        check("nomdu mflo wbvalue", ex_io.ex_mem_wbvalue, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("rst valid", ex_io.ex_mem_valid, 1'b0);
        #2 reset = 1'b1;
`endif

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised EX pipeline stage for the MIPS-style core, between ID/EX and EX/MEM. It computes ALU and shifter results, suppresses register writeback on signed overflow, and registers the EX/MEM bundle. It adds a valid bit, memory-stall hold and flush, and an optional iterative multiply/divide unit with HI/LO registers. While that unit is busy, it asserts a stall request back to decode.

## Interface
- XLEN, 32, datapath width (≥8, power of 2)
- REG_AW, 5, register-index width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_selalushift, id_ex_selimregb, id_ex_unsig, id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_writeov  in  1 each  decode control
- id_ex_aluop  in  3  ALU op (package enum)
- id_ex_shiftop  in  2  0 sll, 1 srl, 2 sra, 3 rotr
- id_ex_shiftamt  in  $clog2(XLEN)  shift amount
- id_ex_mduop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo
- id_ex_rega, id_ex_regb, id_ex_imedext  in  XLEN  operands
- id_ex_regdest  in  REG_AW  destination
- mem_stall  in  1  hold EX/MEM
- flush  in  1  kill instruction entering EX/MEM
- ex_busy  out  1  decode must hold ID/EX (combinational)
- ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg, ex_mem_ovf  out  1 each
- ex_mem_regb, ex_mem_wbvalue  out  XLEN
- ex_mem_regdest  out  REG_AW

## Operation
- B operand = selimregb ? imedext : regb; the shifter always operates on regb.
- wbvalue = mfhi ? HI : mflo ? LO : selalushift ? shift result : ALU result. Mult/div ops write wbvalue 0.
- writereg = valid & writereg & (!aluov | writeov) & mduop∉{1..4}.
- ovf = valid & aluov & !writeov.
- Advance rules, priority: reset > flush > mem_stall > ex_busy > normal.
  - flush: next edge clears valid, readmem, writemem, writereg and ovf. Data fields are don't-care.
  - mem_stall: all ex_mem_* outputs hold.
  - ex_busy: inserts a bubble (valid and all controls 0).
- The MDU is a 2-state FSM, IDLE and RUN.
  - IDLE→RUN when a valid op 1–4 advances: the cycle is not flushed, stalled or busy. On entry it latches the operand magnitudes, the result signs and counter=0. The issuing instruction retires into EX/MEM with writereg=0.
  - RUN performs one shift-add (mult) or one restoring-subtract (div) step per cycle. On counter=XLEN-1 it writes HI/LO and returns to IDLE.
  - Results: mult HI:LO = 2·XLEN-bit product. div LO = quotient, HI = remainder. Quotient sign = sign(a)^sign(b); remainder sign = sign(a). Unsigned ops take no signs.
  - Divide by zero: LO = all ones, HI = rega, for both signed and unsigned.
- ex_busy = id_ex_valid & state==RUN & mduop≠0.
- flush and mem_stall never abort RUN.

## Timing
- ALU, shift and mfhi/mflo results: 1 cycle, captured at the next edge.
- Mult/div issued at edge T: RUN during cycles T..T+XLEN-1; HI/LO written at edge T+XLEN. A dependent mfhi/mflo is captured at edge T+XLEN+1. A mult/div held behind it is accepted at the same edge.
- Reset is asynchronous and applies mid-operation: all ex_mem_* outputs go to 0, state goes to IDLE, counter, HI and LO go to 0, and ex_busy goes to 0 immediately.

## Configuration
- EXEC_MDU_EN defined: MDU, HI/LO and ex_busy are present as described.
- EXEC_MDU_EN undefined: no MDU, HI or LO; ex_busy is tied to 0. Any mduop≠0 passes through as a NOP: valid kept, writereg=0, wbvalue=0.

## Structure
- Shared package exec_pkg holds:
  - aluop, shiftop and mduop enums;
  - the MDU state enum;
  - XLEN and REG_AW defaults.
- One sub-module, exec_mdu: operands, start, op in; busy, hi, lo out. It is instantiated only under EXEC_MDU_EN.
- The existing ALU and shifter blocks are instantiated unchanged, widened by XLEN.

## Test plan (XLEN=32)
- Overflow: add with rega=0x7FFFFFFF, imm=1, selimregb=1, writeov=0 -> wbvalue=0x80000000, writereg=0, ovf=1. Repeat with writeov=1 -> writereg=1, ovf=0.
- mult: rega=0xFFFFFFFD, regb=7, then mflo and mfhi -> 0xFFFFFFEB and 0xFFFFFFFF. ex_busy is high for exactly 32 cycles while the mflo waits.
- div: rega=-7, regb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with rega=5, regb=0 -> LO=0xFFFFFFFF, HI=5.
- Hazard bubbles: mflo immediately after mult -> ex_mem_valid=0 for 32 cycles, then valid=1 with the product.
- Stall and flush: a lw sits in EX/MEM with mem_stall held 3 cycles -> EX/MEM is unchanged. Then assert flush together with mem_stall -> valid, readmem and writereg are 0 after the next edge.
- Reset: drop reset at RUN cycle 10 of a div -> outputs 0 and ex_busy 0 without waiting for a clock edge. After release, mflo returns 0.
